// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Drain stage for the 16-bit sample FIFO. Each word is popped through the FIFO
//   read port, which has a 1-cycle registered read latency. Two consecutive words
//   are packed into one beat on a valid/ready stream. If a single word waits too
//   long for its partner, it is flushed as a half beat after an idle timeout.
//
// Parameters
//   IN_W     FIFO word width; the beat is 2*IN_W wide
//   TIMEOUT  idle cycles in S_HI before a half beat is flushed (0 = never)
//   CNT_W    width of the accepted-beat counter
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read enable (registered)
//   fifo_dout   FIFO read data, valid the cycle after fifo_rd_en
//   m_data      packed beat: low half = first word, high half = second word
//   m_valid     beat valid
//   m_ready     downstream accept
//   m_half      beat holds the first word only; the high half is zero
//   beat_cnt    accepted beats, wraps modulo 2^CNT_W
module fifo_word_packer #(
  parameter int IN_W    = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [IN_W-1:0]   fifo_dout,
  output logic [2*IN_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_half,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_LO, S_HI, S_OUT} state_t;

  state_t              state_q, state_d;
  logic                rd_pend_q, rd_pend_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                fifo_rd_en_q, fifo_rd_en_d;
  logic                m_valid_q, m_valid_d;
  logic [2*IN_W-1:0]   m_data_q, m_data_d;
  logic                m_half_q, m_half_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [IN_W-1:0]     low_q, low_d;
  logic                idle;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_half_d   = m_half_q;
    beat_cnt_d = beat_cnt_q;
    low_d      = low_q;
    // Read data arrives exactly one cycle after the enable.
    rd_pend_d  = fifo_rd_en_q;
    // Idle means nothing is in flight and nothing can be fetched.
    idle       = !rd_pend_q && !fifo_rd_en_q && fifo_empty;

    case (state_q)
      S_LO: begin
        timer_d = '0;
        if (rd_pend_q) begin
          low_d   = fifo_dout;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (rd_pend_q) begin
          m_data_d  = {fifo_dout, low_q};
          m_half_d  = 1'b0;
          m_valid_d = 1'b1;
          state_d   = S_OUT;
          timer_d   = '0;
        end else if (idle) begin
          if (TIMEOUT != 0 && timer_q == TMR_LAST) begin
            m_data_d  = {{IN_W{1'b0}}, low_q};
            m_half_d  = 1'b1;
            m_valid_d = 1'b1;
            state_d   = S_OUT;
            timer_d   = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end else begin
          timer_d = '0;
        end
      end
      S_OUT: begin
        timer_d = '0;
        if (m_valid_q && m_ready) begin
          m_valid_d  = 1'b0;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          state_d    = S_LO;
        end
      end
      default: state_d = S_LO;
    endcase

    // Gating on the next state keeps reads out of S_OUT, so a capture can never
    // land on a held beat. The second read of a pair may be issued while the
    // first word is still being captured; this gives a read every other cycle.
    fifo_rd_en_d = (state_d != S_OUT) && !fifo_empty && !fifo_rd_en_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LO;
      rd_pend_q    <= 1'b0;
      timer_q      <= '0;
      fifo_rd_en_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_half_q     <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rd_pend_q    <= rd_pend_d;
      timer_q      <= timer_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_half_q     <= m_half_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // The held low word is only read after a fresh capture, so it needs no reset.
  always_ff @(posedge clk) begin
    low_q <= low_d;
  end

  assign fifo_rd_en = fifo_rd_en_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_half     = m_half_q;
  assign beat_cnt   = beat_cnt_q;

endmodule
